// File: rtl/write_back_stage.sv
// MEM/WB pipeline register with write-back result selection, register-file write enable
// generation, and a retired-instruction counter.
module write_back_stage #(
    parameter int DATA_W      = 19,
    parameter int REG_AW      = 4,
    parameter int ZERO_REG_HW = 1,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              validM,
    input  logic              stallW,
    input  logic              flushW,
    input  logic [DATA_W-1:0] aluresultM,
    input  logic [DATA_W-1:0] readdataM,
    input  logic [DATA_W-1:0] pcplus1M,
    input  logic [DATA_W-1:0] immextM,
    input  logic [1:0]        resultsrcM,
    input  logic              regwriteM,
    input  logic [REG_AW-1:0] rdM,
    output logic [DATA_W-1:0] resultW,
    output logic [REG_AW-1:0] rdW,
    output logic              regwriteW,
    output logic              validW,
    output logic [CNT_W-1:0]  retired_cnt
);

    // Handshake: validM qualifies the whole M-side bundle. There is no ready; stallW is the
    // backpressure (all WB fields hold) and flushW discards the incoming bundle (beats stall).
    logic              validQ;
    logic              regwriteQ;
    logic [REG_AW-1:0] rdQ;
    logic [1:0]        resultsrcQ;
    logic [DATA_W-1:0] aluQ;
    logic [DATA_W-1:0] memQ;
    logic [DATA_W-1:0] pcQ;
    logic [DATA_W-1:0] immQ;
    logic [CNT_W-1:0]  retiredQ;
    logic              rdZeroBlocked;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            validQ     <= 1'b0;
            regwriteQ  <= 1'b0;
            rdQ        <= '0;
            resultsrcQ <= 2'b00;
            aluQ       <= '0;
            memQ       <= '0;
            pcQ        <= '0;
            immQ       <= '0;
            retiredQ   <= '0;
        end else begin
            if (flushW) begin
                validQ    <= 1'b0;
                regwriteQ <= 1'b0;
            end else if (!stallW) begin
                validQ     <= validM;
                regwriteQ  <= regwriteM;
                rdQ        <= rdM;
                resultsrcQ <= resultsrcM;
                aluQ       <= aluresultM;
                memQ       <= readdataM;
                pcQ        <= pcplus1M;
                immQ       <= immextM;
            end
            // Flush kills the incoming instruction only; the one leaving WB still retires.
            if (validQ && !stallW)
                retiredQ <= retiredQ + CNT_W'(1);
        end
    end

    always_comb begin
        resultW = aluQ;
        case (resultsrcQ)
            2'b00:   resultW = aluQ;
            2'b01:   resultW = memQ;
            2'b10:   resultW = pcQ;
            default: resultW = immQ;
        endcase
    end

    assign rdZeroBlocked = (ZERO_REG_HW != 0) && (rdQ == '0);
    assign regwriteW     = validQ & regwriteQ & ~rdZeroBlocked;
    assign rdW           = rdQ;
    assign validW        = validQ;
    assign retired_cnt   = retiredQ;

endmodule

// File: tb/tb_write_back_stage.sv
// Scoreboard bench for write_back_stage: a default-parameter instance and a second instance
// with writable register 0 and a 4-bit retire counter, both fed from the same stimulus.
module tb_write_back_stage;

    localparam int DW = 19;
    localparam int AW = 4;
    localparam int EW = DW + AW + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          validM, stallW, flushW, regwriteM;
    logic [DW-1:0] aluresultM, readdataM, pcplus1M, immextM;
    logic [1:0]    resultsrcM;
    logic [AW-1:0] rdM;

    logic [DW-1:0] res0, res1;
    logic [AW-1:0] rd0, rd1;
    logic          rw0, rw1, v0, v1;
    logic [15:0]   cnt0;
    logic [3:0]    cnt1;

    // {result, rd, regwrite (reg0 suppressed), regwrite (reg0 writable)}
    logic [EW-1:0] exp_q[$];
    logic [31:0]   expCnt = 0;
    int            total = 0;
    int            bad = 0;

    write_back_stage #(.DATA_W(DW), .REG_AW(AW), .ZERO_REG_HW(1), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .validM(validM), .stallW(stallW), .flushW(flushW),
        .aluresultM(aluresultM), .readdataM(readdataM), .pcplus1M(pcplus1M), .immextM(immextM),
        .resultsrcM(resultsrcM), .regwriteM(regwriteM), .rdM(rdM),
        .resultW(res0), .rdW(rd0), .regwriteW(rw0), .validW(v0), .retired_cnt(cnt0)
    );

    write_back_stage #(.DATA_W(DW), .REG_AW(AW), .ZERO_REG_HW(0), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .validM(validM), .stallW(stallW), .flushW(flushW),
        .aluresultM(aluresultM), .readdataM(readdataM), .pcplus1M(pcplus1M), .immextM(immextM),
        .resultsrcM(resultsrcM), .regwriteM(regwriteM), .rdM(rdM),
        .resultW(res1), .rdW(rd1), .regwriteW(rw1), .validW(v1), .retired_cnt(cnt1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Drive one cycle of M-side inputs; anything that will be captured gets its expectation queued.
    task automatic step(input logic v, input logic rw, input logic [AW-1:0] rd,
                        input logic [1:0] src, input logic [DW-1:0] alu, input logic [DW-1:0] mem,
                        input logic [DW-1:0] pc, input logic [DW-1:0] imm,
                        input logic stall, input logic flush, input logic [DW-1:0] expRes);
        validM = v;   regwriteM = rw;  rdM = rd;       resultsrcM = src;
        aluresultM = alu; readdataM = mem; pcplus1M = pc; immextM = imm;
        stallW = stall; flushW = flush;
        if (v && !stall && !flush)
            exp_q.push_back({expRes, rd, (rw && (rd != 4'd0)), rw});
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'd0, 2'd0, 19'h0, 19'h0, 19'h0, 19'h0, 1'b0, 1'b0, 19'h0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_res0"}, 32'(res0), 32'h0);
        check({tag, "_rd0"},  32'(rd0),  32'h0);
        check({tag, "_rw0"},  32'(rw0),  32'h0);
        check({tag, "_v0"},   32'(v0),   32'h0);
        check({tag, "_cnt0"}, 32'(cnt0), 32'h0);
        check({tag, "_rw1"},  32'(rw1),  32'h0);
        check({tag, "_cnt1"}, 32'(cnt1), 32'h0);
    endtask

    // Monitor: WB contents are stable here; the next rising edge retires when validW && !stallW.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (!rst) begin
            check("cnt16", 32'(cnt0), {16'h0, expCnt[15:0]});
            check("cnt4",  32'(cnt1), {28'h0, expCnt[3:0]});
            if (v0) begin
                check("valid1", 32'(v1), 32'h1);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid actual=rd%0d required=empty", rd0);
                end else begin
                    e = exp_q[0];
                    check("result0",   32'(res0), 32'(e[EW-1 -: DW]));
                    check("result1",   32'(res1), 32'(e[EW-1 -: DW]));
                    check("rd",        32'(rd0),  32'(e[5:2]));
                    check("regwrite0", 32'(rw0),  32'(e[1]));
                    check("regwrite1", 32'(rw1),  32'(e[0]));
                    if (!stallW) begin
                        void'(exp_q.pop_front());
                        expCnt++;
                    end else if (flushW) begin
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                check("valid1_idle", 32'(v1),  32'h0);
                check("bubble_rw0",  32'(rw0), 32'h0);
                check("bubble_rw1",  32'(rw1), 32'h0);
            end
        end
    end

    initial begin
        rst = 1'b1;
        validM = 0; stallW = 0; flushW = 0; regwriteM = 0; rdM = 0; resultsrcM = 0;
        aluresultM = 0; readdataM = 0; pcplus1M = 0; immextM = 0;
        #3;
        check_all_zero("reset_init");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Source select, one per cycle
        step(1, 1, 4'd5, 2'd0, 19'h12345, 19'h7ABCD, 19'h00010, 19'h40000, 0, 0, 19'h12345);
        step(1, 1, 4'd5, 2'd1, 19'h12345, 19'h7ABCD, 19'h00010, 19'h40000, 0, 0, 19'h7ABCD);
        step(1, 1, 4'd5, 2'd2, 19'h12345, 19'h7ABCD, 19'h00010, 19'h40000, 0, 0, 19'h00010);
        step(1, 1, 4'd5, 2'd3, 19'h12345, 19'h7ABCD, 19'h00010, 19'h40000, 0, 0, 19'h40000);

        // Stall three cycles with changing inputs, then flush together with stall
        step(1, 1, 4'd3, 2'd0, 19'h00AAA, 19'h11111, 19'h22222, 19'h33333, 0, 0, 19'h00AAA);
        step(1, 1, 4'd9, 2'd1, 19'h05555, 19'h06666, 19'h07777, 19'h01111, 1, 0, 19'h0);
        step(1, 0, 4'd1, 2'd2, 19'h05556, 19'h06667, 19'h07778, 19'h01112, 1, 0, 19'h0);
        step(0, 1, 4'd2, 2'd3, 19'h05557, 19'h06668, 19'h07779, 19'h01113, 1, 0, 19'h0);
        step(1, 1, 4'd6, 2'd0, 19'h03333, 19'h0, 19'h0, 19'h0, 1, 1, 19'h0);
        idle();

        // Register 0 writes, and a non-writing instruction to register 0
        step(1, 1, 4'd0, 2'd0, 19'h01234, 19'h0, 19'h0, 19'h0, 0, 0, 19'h01234);
        step(1, 0, 4'd0, 2'd1, 19'h0, 19'h00321, 19'h0, 19'h0, 0, 0, 19'h00321);

        // Bubble carrying regwrite
        step(0, 1, 4'd4, 2'd0, 19'h7FFFF, 19'h0, 19'h0, 19'h0, 0, 0, 19'h0);
        idle();

        // Flush without stall: WB instruction retires, incoming one is killed
        step(1, 1, 4'd2, 2'd2, 19'h0, 19'h0, 19'h0ABCD, 19'h0, 0, 0, 19'h0ABCD);
        step(1, 1, 4'd8, 2'd0, 19'h11111, 19'h0, 19'h0, 19'h0, 0, 1, 19'h0);
        idle();

        // Full-width immediate, highest register
        step(1, 1, 4'd15, 2'd3, 19'h0, 19'h0, 19'h0, 19'h7FFFF, 0, 0, 19'h7FFFF);

        // Asynchronous reset between edges while WB holds a valid writing instruction
        step(1, 1, 4'd7, 2'd0, 19'h2468A, 19'h0, 19'h0, 19'h0, 0, 0, 19'h2468A);
        validM = 0; regwriteM = 0; stallW = 1; flushW = 0;
        #2;
        check("pre_reset_valid", 32'(v0),  32'h1);
        check("pre_reset_rw",    32'(rw0), 32'h1);
        rst = 1'b1;
        exp_q.delete();
        expCnt = 0;
        #1;
        check_all_zero("reset_mid");
        stallW = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 17 back-to-back retirements: the 4-bit counter wraps through 0 to 1
        for (int i = 0; i < 17; i++)
            step(1, 1, 4'(i % 15 + 1), 2'd0, 19'(i * 37 + 5), 19'h0, 19'h0, 19'h0, 0, 0,
                 19'(i * 37 + 5));
        repeat (3) idle();

        check("queue_empty", 32'(exp_q.size()), 32'h0);
        check("final_cnt16", 32'(cnt0), 32'd17);
        check("final_cnt4",  32'(cnt1), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
